// File: rtl/sad_search_ctrl.sv
// Motion-search scheduler: issues one SAD job per candidate, tracks the minimum SAD/index, aborts on watchdog.
// Optional build macro SAD_SEARCH_EARLY_EXIT_EN stops the search as soon as a zero SAD is seen.
module sad_search_ctrl #(
    parameter int NUM_CAND = 16,
    parameter int SAD_W    = 16,
    parameter int TIMEOUT  = 1024,
    parameter int IDX_W    = $clog2(NUM_CAND)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             sad_go,
    output logic [IDX_W-1:0] sad_cand,
    input  logic             sad_done,
    input  logic [SAD_W-1:0] sad_val,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] best_idx,
    output logic [SAD_W-1:0] best_sad
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CMP   = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [IDX_W-1:0] LAST_CAND  = IDX_W'(NUM_CAND - 1);
    localparam logic [WD_W-1:0]  WD_EXPIRED = WD_W'(TIMEOUT);

`ifdef SAD_SEARCH_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    logic [2:0]       state_q,    state_d;
    logic [IDX_W-1:0] cand_q,     cand_d;
    logic [WD_W-1:0]  wdog_q,     wdog_d;
    logic [SAD_W-1:0] cur_sad_q,  cur_sad_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic             err_q,      err_d;
    logic             sad_go_q,   sad_go_d;
    logic             done_q,     done_d;
    logic             busy_q,     busy_d;

    // Strict comparison so that ties keep the earlier (lower) candidate index.
    function automatic logic is_better(input logic [SAD_W-1:0] cand_sad,
                                       input logic [SAD_W-1:0] ref_sad);
        return (cand_sad < ref_sad);
    endfunction

    // Next-state, datapath and output-decode logic for the search sequencer.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        wdog_d     = wdog_q;
        cur_sad_d  = cur_sad_q;
        best_idx_d = best_idx_q;
        best_sad_d = best_sad_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ISSUE;
                    cand_d     = '0;
                    best_sad_d = '1;
                    best_idx_d = '0;
                    err_d      = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the expiry cycle still wins over the abort.
                if (sad_done) begin
                    cur_sad_d = sad_val;
                    state_d   = S_CMP;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                    if ((wdog_q + WD_W'(1)) == WD_EXPIRED) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_CMP: begin
                if (is_better(cur_sad_q, best_sad_q)) begin
                    best_sad_d = cur_sad_q;
                    best_idx_d = cand_q;
                end else begin
                    best_sad_d = best_sad_q;
                end
                if ((cand_q == LAST_CAND) || (EARLY_EXIT && (cur_sad_q == '0))) begin
                    state_d = S_FIN;
                end else begin
                    cand_d  = cand_q + IDX_W'(1);
                    state_d = S_ISSUE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they can be driven straight from flops.
        sad_go_d = (state_d == S_ISSUE);
        done_d   = (state_d == S_FIN);
        busy_d   = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cand_q     <= '0;
            wdog_q     <= '0;
            cur_sad_q  <= '0;
            best_idx_q <= '0;
            best_sad_q <= '0;
            err_q      <= 1'b0;
            sad_go_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            wdog_q     <= wdog_d;
            cur_sad_q  <= cur_sad_d;
            best_idx_q <= best_idx_d;
            best_sad_q <= best_sad_d;
            err_q      <= err_d;
            sad_go_q   <= sad_go_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign sad_go   = sad_go_q;
    assign sad_cand = cand_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign best_idx = best_idx_q;
    assign best_sad = best_sad_q;

endmodule
